// File: rtl/lms2lab_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lms2lab_mac_sequencer
// Brief    : Sequential 3x3 matrix-vector MAC (log-LMS -> lab), one multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module lms2lab_mac_sequencer #(
    parameter int FRAC  = 13,
    parameter int ACC_W = 34
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic signed [15:0] i_logL,
    input  logic signed [15:0] i_logM,
    input  logic signed [15:0] i_logS,
    output logic               o_valid,
    input  logic               i_ready,
    output logic signed [15:0] o_l,
    output logic signed [15:0] o_a,
    output logic signed [15:0] o_b,
    input  logic               i_cfg_we,
    input  logic        [3:0]  i_cfg_addr,
    input  logic signed [15:0] i_cfg_data,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic signed [15:0] c_DEF_COEF [0:8] = '{
        16'sh127A, 16'sh127A, 16'sh127A,
        16'sh0D10, 16'sh0D10, 16'shE5DF,
        16'sh16A1, 16'shE95F, 16'sh0000
    };
    localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-32768);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic        [1:0]        r_row;
    logic        [1:0]        r_col;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [15:0]       r_vec  [0:2];
    logic signed [15:0]       r_coef [0:8];
    logic signed [15:0]       r_l;
    logic signed [15:0]       r_a;
    logic signed [15:0]       r_b;

    logic        [3:0]        w_idx;
    logic signed [15:0]       w_coef_sel;
    logic signed [15:0]       w_vec_sel;
    logic signed [31:0]       w_prod;
    logic signed [ACC_W-1:0]  w_acc_base;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [15:0]       w_row_res;
    logic                     w_last;
    logic                     w_cfg_ok;

    // Single shared multiplier: coefficient picked by (row, col), vector by col
    assign w_idx      = {1'b0, r_row, 1'b0} + {2'b00, r_row} + {2'b00, r_col};
    assign w_coef_sel = r_coef[w_idx];
    assign w_vec_sel  = r_vec[r_col];
    assign w_prod     = w_coef_sel * w_vec_sel;
    assign w_acc_base = (r_col == 2'd0) ? '0 : r_acc;
    assign w_acc_nxt  = w_acc_base + ACC_W'(w_prod);
    assign w_shift    = w_acc_nxt >>> FRAC;
    assign w_last     = (r_row == 2'd2) && (r_col == 2'd2);
    assign w_cfg_ok   = i_cfg_we && (i_cfg_addr <= 4'd8) && (r_state != ST_MAC);

    always_comb begin
        w_row_res = w_shift[15:0];
        if (w_shift > c_SAT_MAX) begin
            w_row_res = 16'sh7FFF;
        end else if (w_shift < c_SAT_MIN) begin
            w_row_res = 16'sh8000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                o_busy = 1'b1;
                if (w_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                o_valid = 1'b1;
                if (i_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Coefficient write shares the edge with a transfer, so the new value is
    // already in place for the first MAC cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row <= 2'd0;
            r_col <= 2'd0;
            r_acc <= '0;
            r_l   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            for (int i = 0; i < 3; i++) r_vec[i] <= '0;
            for (int i = 0; i < 9; i++) r_coef[i] <= c_DEF_COEF[i];
        end else begin
            if (w_cfg_ok) begin
                r_coef[i_cfg_addr] <= i_cfg_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_vec[0] <= i_logL;
                        r_vec[1] <= i_logM;
                        r_vec[2] <= i_logS;
                        r_row    <= 2'd0;
                        r_col    <= 2'd0;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_nxt;
                    if (r_col == 2'd2) begin
                        r_col <= 2'd0;
                        r_row <= (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
                        case (r_row)
                            2'd0:    r_l <= w_row_res;
                            2'd1:    r_a <= w_row_res;
                            default: r_b <= w_row_res;
                        endcase
                    end else begin
                        r_col <= r_col + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_l = r_l;
    assign o_a = r_a;
    assign o_b = r_b;

endmodule
`default_nettype wire

// File: tb/tb_lms2lab_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms2lab_mac_sequencer
// Brief    : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lms2lab_mac_sequencer;

    localparam int FRAC = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        rdy;
    logic [15:0] logL, logM, logS;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        dut_ready, dut_valid, dut_busy;
    logic [15:0] dut_l, dut_a, dut_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_coef [9];

    typedef struct {
        logic [15:0] L, M, S;
        logic [15:0] el, ea, eb;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    lms2lab_mac_sequencer #(.FRAC(13), .ACC_W(34)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (vld),
        .o_ready    (dut_ready),
        .i_logL     (logL),
        .i_logM     (logM),
        .i_logS     (logS),
        .o_valid    (dut_valid),
        .i_ready    (rdy),
        .o_l        (dut_l),
        .o_a        (dut_a),
        .o_b        (dut_b),
        .i_cfg_we   (cfg_we),
        .i_cfg_addr (cfg_addr),
        .i_cfg_data (cfg_data),
        .o_busy     (dut_busy)
    );

    task automatic model_reset();
        m_coef = '{16'h127A, 16'h127A, 16'h127A, 16'h0D10, 16'h0D10,
                   16'hE5DF, 16'h16A1, 16'hE95F, 16'h0000};
    endtask

    // Row result = saturate(floor(sum(coef*vec) / 2^FRAC))
    function automatic logic [15:0] model_row(input int r, input logic [15:0] L,
                                              input logic [15:0] M, input logic [15:0] S);
        longint v [3];
        longint s;
        v[0] = longint'($signed(L));
        v[1] = longint'($signed(M));
        v[2] = longint'($signed(S));
        s = 0;
        for (int c = 0; c < 3; c++) s += longint'($signed(m_coef[3*r+c])) * v[c];
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
        if (a <= 4'd8) m_coef[a] = d;
    endtask

    task automatic start_xfer(input logic [15:0] L, input logic [15:0] M, input logic [15:0] S);
        logL = L; logM = M; logS = S; vld = 1'b1;
        step();
        vld = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!dut_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    // o_valid is registered on the 9th edge after the transfer edge T,
    // so it is first sampled high by edge T+10.
    task automatic run_txn(input logic [15:0] L, input logic [15:0] M, input logic [15:0] S,
                           input string name, output logic [15:0] rl,
                           output logic [15:0] ra, output logic [15:0] rb);
        int n;
        start_xfer(L, M, S);
        chk({name, "_busy"}, {dut_busy, dut_ready}, 2'b10);
        wait_valid(n);
        chk({name, "_latency"}, n, 9);
        rl = dut_l; ra = dut_a; rb = dut_b;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk({name, "_release"}, {dut_valid, dut_ready}, 2'b01);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rl, ra, rb, h_l, h_a, h_b;
        logic [15:0] L, M, S;
        logic [47:0] exp_q [$];
        int n, cnt, xfer, got, last_xfer, cyc;
        logic pre_ready;

        rst = 1'b1; vld = 1'b0; rdy = 1'b0;
        logL = '0; logM = '0; logS = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();

        tbl[0] = '{16'h2000, 16'h2000, 16'h2000, 16'h376E, 16'hFFFF, 16'h0000};
        tbl[1] = '{16'h2000, 16'h0000, 16'h0000, 16'h127A, 16'h0D10, 16'h16A1};
        tbl[2] = '{16'h0000, 16'h2000, 16'h0000, 16'h127A, 16'h0D10, 16'hE95F};
        tbl[3] = '{16'h0000, 16'h0000, 16'h2000, 16'h127A, 16'hE5DF, 16'h0000};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[5] = '{16'hE000, 16'hE000, 16'hE000, 16'hC892, 16'h0001, 16'h0000};
        tbl[6] = '{16'h1000, 16'h0000, 16'h0000, 16'h093D, 16'h0688, 16'h0B50};
        tbl[7] = '{16'h0000, 16'h1000, 16'h0000, 16'h093D, 16'h0688, 16'hF4AF};

        // Reset state
        step(); step();
        chk("reset_ctrl", {dut_ready, dut_valid, dut_busy}, 3'b100);
        chk("reset_out", {dut_l, dut_a, dut_b}, 48'h0);
        rst = 1'b0;

        // Vector table with default matrix
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].L, tbl[i].M, tbl[i].S, $sformatf("tbl%0d", i), rl, ra, rb);
            chk($sformatf("tbl%0d_res", i), {rl, ra, rb}, {tbl[i].el, tbl[i].ea, tbl[i].eb});
            chk($sformatf("tbl%0d_model", i), {rl, ra, rb},
                {model_row(0, tbl[i].L, tbl[i].M, tbl[i].S),
                 model_row(1, tbl[i].L, tbl[i].M, tbl[i].S),
                 model_row(2, tbl[i].L, tbl[i].M, tbl[i].S)});
            chk($sformatf("tbl%0d_idle_hold", i), {dut_l, dut_a, dut_b}, {rl, ra, rb});
        end

        // Back-pressure in OUT with an ignored i_valid pulse
        start_xfer(16'h2000, 16'h0000, 16'h0000);
        wait_valid(n);
        chk("bp_latency", n, 9);
        h_l = dut_l; h_a = dut_a; h_b = dut_b;
        chk("bp_result", {h_l, h_a, h_b}, 48'h127A_0D10_16A1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            vld = (i == 1 || i == 3);
            logL = 16'h1234; logM = 16'h4321; logS = 16'h7777;
            step();
            if ({dut_valid, dut_ready, dut_busy, dut_l, dut_a, dut_b} !== {3'b100, h_l, h_a, h_b})
                cnt++;
        end
        vld = 1'b0;
        chk("bp_stable", cnt, 0);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("bp_release", {dut_valid, dut_ready}, 2'b01);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dut_valid || dut_busy) cnt++;
        end
        chk("bp_single_result", cnt, 0);

        // Positive and negative saturation
        cfg_write(4'd0, 16'h7FFF); cfg_write(4'd1, 16'h7FFF); cfg_write(4'd2, 16'h7FFF);
        run_txn(16'h7FFF, 16'h7FFF, 16'h7FFF, "sat_pos", rl, ra, rb);
        chk("sat_pos_l", rl, 16'h7FFF);
        chk("sat_pos_ab", {ra, rb}, {model_row(1, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                                     model_row(2, 16'h7FFF, 16'h7FFF, 16'h7FFF)});
        run_txn(16'h8000, 16'h8000, 16'h8000, "sat_neg", rl, ra, rb);
        chk("sat_neg_l", rl, 16'h8000);

        // Write coincident with transfer is used by that computation
        do_reset();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h0000;
        logL = 16'h2000; logM = 16'h0000; logS = 16'h0000; vld = 1'b1;
        step();
        cfg_we = 1'b0; vld = 1'b0;
        m_coef[0] = 16'h0000;
        wait_valid(n);
        chk("coinc_l", {dut_l, dut_a, dut_b}, 48'h0000_0D10_16A1);
        rdy = 1'b1; step(); rdy = 1'b0;

        // Write during MAC cycle 3 is ignored; out-of-range address ignored
        do_reset();
        start_xfer(16'h2000, 16'h2000, 16'h2000);
        step(); step(); step();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h0000;
        step();
        cfg_we = 1'b0;
        wait_valid(n);
        chk("macwr_res", {dut_l, dut_a, dut_b}, 48'h376E_FFFF_0000);
        rdy = 1'b1; step(); rdy = 1'b0;
        cfg_write(4'd9, 16'h0000);
        cfg_write(4'd15, 16'h0000);
        run_txn(16'h2000, 16'h2000, 16'h2000, "badaddr", rl, ra, rb);
        chk("badaddr_res", {rl, ra, rb}, 48'h376E_FFFF_0000);

        // Reset at MAC cycle 5 restores defaults and suppresses the result
        cfg_write(4'd0, 16'h0000);
        start_xfer(16'h2000, 16'h2000, 16'h2000);
        step(); step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("midrst_ctrl", {dut_ready, dut_valid, dut_busy}, 3'b100);
        chk("midrst_out", {dut_l, dut_a, dut_b}, 48'h0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (dut_valid) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        run_txn(16'h2000, 16'h2000, 16'h2000, "midrst_defaults", rl, ra, rb);
        chk("midrst_def_res", {rl, ra, rb}, 48'h376E_FFFF_0000);

        // Reset while in OUT
        start_xfer(16'h2000, 16'h0000, 16'h0000);
        wait_valid(n);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("outrst_ctrl", {dut_ready, dut_valid, dut_busy, dut_l}, {3'b100, 16'h0});

        // Randomized coefficients and vectors against the model
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 3; w++)
                cfg_write(4'($urandom_range(0, 15)), 16'($urandom));
            L = 16'($urandom); M = 16'($urandom); S = 16'($urandom);
            run_txn(L, M, S, $sformatf("rnd%0d", it), rl, ra, rb);
            chk($sformatf("rnd%0d_res", it), {rl, ra, rb},
                {model_row(0, L, M, S), model_row(1, L, M, S), model_row(2, L, M, S)});
        end

        // Back-to-back with i_valid and i_ready held high
        rdy = 1'b1; vld = 1'b1;
        logL = 16'($urandom); logM = 16'($urandom); logS = 16'($urandom);
        xfer = 0; got = 0; last_xfer = 0; cyc = 0;
        while (got < 4 && cyc < 80) begin
            pre_ready = dut_ready;
            step();
            cyc++;
            if (pre_ready && vld) begin
                xfer++;
                if (xfer > 1) chk("b2b_interval", cyc - last_xfer, 11);
                last_xfer = cyc;
                exp_q.push_back({model_row(0, logL, logM, logS), model_row(1, logL, logM, logS),
                                 model_row(2, logL, logM, logS)});
                logL = 16'($urandom); logM = 16'($urandom); logS = 16'($urandom);
                if (xfer == 4) vld = 1'b0;
            end
            if (dut_valid) begin
                got++;
                if (exp_q.size() > 0) chk("b2b_res", {dut_l, dut_a, dut_b}, exp_q.pop_front());
                else chk("b2b_unexpected", 1, 0);
            end
        end
        chk("b2b_count", got, 4);
        step();
        rdy = 1'b0; vld = 1'b0;
        chk("b2b_end", {dut_ready, dut_valid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
